costas_phase_detect: RTL and testbench

COSTAS_PHASE_DETECT -- requirements
Module: costas_phase_detect

---
 rtl/costas_phase_detect.sv | 206 ++++++++++++++++++++
 tb/tb_costas_phase_detect.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/costas_phase_detect.sv
// Costas-loop phase detector for BPSK/QPSK: decision-rotates I/Q, produces a
// saturated phase error, blanks the error while settling and tracks lock.
module costas_phase_detect #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_THRESH   = 1024,
  parameter int LOCK_COUNT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic signed [WIDTH-1:0] in_I_tdata,
  input  logic                    in_I_tvalid,
  input  logic signed [WIDTH-1:0] in_Q_tdata,
  input  logic                    in_Q_tvalid,
  output logic signed [WIDTH-1:0] out_I_tdata,
  output logic signed [WIDTH-1:0] out_Q_tdata,
  output logic                    out_tvalid,
  output logic signed [WIDTH-1:0] error_tdata,
  output logic                    error_tvalid,
  output logic [1:0]              mode_active,
  output logic                    settling,
  output logic                    locked
);

  localparam int WP1 = WIDTH + 1;
  localparam logic [1:0] MODE_BPSK = 2'b00;
  localparam logic [1:0] MODE_QPSK = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;
  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LOCK_MAX    = 16'(LOCK_COUNT);
  localparam logic [WIDTH:0] THRESH   = WP1'(LOCK_THRESH);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] r;
    if (x == S_MIN) r = S_MAX;
    else            r = -x;
    return r;
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_narrow(input logic [WIDTH:0] x);
    logic signed [WIDTH-1:0] r;
    if (x[WIDTH] != x[WIDTH-1]) r = x[WIDTH] ? S_MIN : S_MAX;
    else                        r = x[WIDTH-1:0];
    return r;
  endfunction

  state_t                  state_r;
  logic [15:0]             settle_cnt_r;
  logic [1:0]              mode_active_r;
  logic [1:0]              mode_eff_s;
  logic                    mode_change_s;
  logic                    accept_s;

  logic                    s1_valid_r;
  logic signed [WIDTH-1:0] s1_i_r;
  logic signed [WIDTH-1:0] s1_q_r;
  logic [1:0]              s1_mode_r;
  logic                    s1_blank_r;

  logic signed [WIDTH-1:0] fold_i_s;
  logic signed [WIDTH-1:0] fold_q_s;
  logic [WIDTH:0]          diff_s;
  logic signed [WIDTH-1:0] rot_i_s;
  logic signed [WIDTH-1:0] rot_q_s;
  logic signed [WIDTH-1:0] err_raw_s;
  logic signed [WIDTH-1:0] err_s;

  logic signed [WIDTH-1:0] out_i_r;
  logic signed [WIDTH-1:0] out_q_r;
  logic signed [WIDTH-1:0] error_r;
  logic                    out_valid_r;
  logic                    eval_r;

  logic [WIDTH:0]          err_ext_s;
  logic [WIDTH:0]          err_mag_s;
  logic                    in_thresh_s;
  logic [15:0]             lock_cnt_r;
  logic                    locked_r;

  // Map the reserved mode code onto BPSK and detect a request to switch.
  always_comb begin
    mode_eff_s = MODE_BPSK;
    case (mode)
      MODE_QPSK: mode_eff_s = MODE_QPSK;
      MODE_HOLD: mode_eff_s = MODE_HOLD;
      default:   mode_eff_s = MODE_BPSK;
    endcase
    mode_change_s = (mode_eff_s != mode_active_r);
    accept_s      = in_I_tvalid & in_Q_tvalid;
  end

  // Mode/settle controller: any mode switch (re)starts the blanking window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_SETTLE;
      settle_cnt_r  <= SETTLE_LOAD;
      mode_active_r <= MODE_BPSK;
    end else if (mode_change_s) begin
      state_r       <= ST_SETTLE;
      settle_cnt_r  <= SETTLE_LOAD;
      mode_active_r <= mode_eff_s;
    end else if (state_r == ST_SETTLE) begin
      if (settle_cnt_r == 16'd0) state_r <= ST_RUN;
      else                       settle_cnt_r <= settle_cnt_r - 16'd1;
    end
  end

  // Stage 1: capture the sample with the mode and blanking in force when accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_i_r     <= {WIDTH{1'b0}};
      s1_q_r     <= {WIDTH{1'b0}};
      s1_mode_r  <= MODE_BPSK;
      s1_blank_r <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_i_r     <= in_I_tdata;
        s1_q_r     <= in_Q_tdata;
        s1_mode_r  <= mode_active_r;
        s1_blank_r <= (state_r == ST_SETTLE);
      end
    end
  end

  // Decision rotation and phase error for the stage-1 sample.
  always_comb begin
    fold_q_s  = s1_i_r[WIDTH-1] ? neg_sat(s1_q_r) : s1_q_r;
    fold_i_s  = s1_q_r[WIDTH-1] ? neg_sat(s1_i_r) : s1_i_r;
    diff_s    = {fold_q_s[WIDTH-1], fold_q_s} - {fold_i_s[WIDTH-1], fold_i_s};
    rot_i_s   = s1_i_r;
    rot_q_s   = s1_q_r;
    err_raw_s = {WIDTH{1'b0}};
    case (s1_mode_r)
      MODE_QPSK: begin
        rot_i_s   = fold_i_s;
        rot_q_s   = fold_q_s;
        err_raw_s = sat_narrow(diff_s);
      end
      MODE_HOLD: err_raw_s = {WIDTH{1'b0}};
      default:   err_raw_s = fold_q_s;
    endcase
    if (s1_blank_r) err_s = {WIDTH{1'b0}};
    else            err_s = err_raw_s;
  end

  // Stage 2: output registers; data holds when no sample arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      eval_r      <= 1'b0;
      out_i_r     <= {WIDTH{1'b0}};
      out_q_r     <= {WIDTH{1'b0}};
      error_r     <= {WIDTH{1'b0}};
    end else begin
      out_valid_r <= s1_valid_r;
      eval_r      <= s1_valid_r & ~s1_blank_r & (s1_mode_r != MODE_HOLD);
      if (s1_valid_r) begin
        out_i_r <= rot_i_s;
        out_q_r <= rot_q_s;
        error_r <= err_s;
      end
    end
  end

  // Magnitude in WIDTH+1 bits so the most negative error cannot wrap.
  always_comb begin
    err_ext_s   = {error_r[WIDTH-1], error_r};
    if (err_ext_s[WIDTH]) err_mag_s = {(WIDTH+1){1'b0}} - err_ext_s;
    else                  err_mag_s = err_ext_s;
    in_thresh_s = (err_mag_s < THRESH);
  end

  // Lock detector on the emitted error stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_r <= 16'd0;
      locked_r   <= 1'b0;
    end else if (mode_change_s || (eval_r && !in_thresh_s)) begin
      lock_cnt_r <= 16'd0;
      locked_r   <= 1'b0;
    end else begin
      if (eval_r && (lock_cnt_r != LOCK_MAX)) lock_cnt_r <= lock_cnt_r + 16'd1;
      if (lock_cnt_r == LOCK_MAX) locked_r <= 1'b1;
    end
  end

  assign out_I_tdata  = out_i_r;
  assign out_Q_tdata  = out_q_r;
  assign error_tdata  = error_r;
  assign out_tvalid   = out_valid_r;
  assign error_tvalid = out_valid_r;
  assign mode_active  = mode_active_r;
  assign settling     = (state_r == ST_SETTLE);
  assign locked       = locked_r;

endmodule

// File: tb/tb_costas_phase_detect.sv
// Directed bench for costas_phase_detect: vector table over all modes plus
// hand-written sequences for reset, settle timing, lock and HOLD behaviour.
module tb_costas_phase_detect;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         mode;
  logic signed [15:0] in_I_tdata, in_Q_tdata;
  logic               in_I_tvalid, in_Q_tvalid;
  logic signed [15:0] out_I_tdata, out_Q_tdata, error_tdata;
  logic               out_tvalid, error_tvalid, settling, locked;
  logic [1:0]         mode_active;

  int checks = 0;
  int errors = 0;

  costas_phase_detect #(
    .WIDTH(16), .SETTLE_CYCLES(4), .LOCK_THRESH(100), .LOCK_COUNT(4)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_I_tdata(in_I_tdata), .in_I_tvalid(in_I_tvalid),
    .in_Q_tdata(in_Q_tdata), .in_Q_tvalid(in_Q_tvalid),
    .out_I_tdata(out_I_tdata), .out_Q_tdata(out_Q_tdata), .out_tvalid(out_tvalid),
    .error_tdata(error_tdata), .error_tvalid(error_tvalid),
    .mode_active(mode_active), .settling(settling), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int i; int q;
    int ei; int eq; int ee;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int i, input int q);
    in_I_tdata  = 16'(i);
    in_Q_tdata  = 16'(q);
    in_I_tvalid = v;
    in_Q_tvalid = v;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input int ei, input int eq, input int ee);
    chk({name, ".out_tvalid"}, int'(out_tvalid), 1);
    chk({name, ".error_tvalid"}, int'(error_tvalid), 1);
    chk({name, ".out_I"}, int'(out_I_tdata), ei);
    chk({name, ".out_Q"}, int'(out_Q_tdata), eq);
    chk({name, ".error"}, int'(error_tdata), ee);
  endtask

  task automatic chk_reset(input string name);
    chk({name, ".out_tvalid"}, int'(out_tvalid), 0);
    chk({name, ".error_tvalid"}, int'(error_tvalid), 0);
    chk({name, ".out_I"}, int'(out_I_tdata), 0);
    chk({name, ".out_Q"}, int'(out_Q_tdata), 0);
    chk({name, ".error"}, int'(error_tdata), 0);
    chk({name, ".settling"}, int'(settling), 1);
    chk({name, ".mode_active"}, int'(mode_active), 0);
    chk({name, ".locked"}, int'(locked), 0);
  endtask

  function automatic logic [1:0] map_mode(input logic [1:0] m);
    return (m == 2'b11) ? 2'b00 : m;
  endfunction

  initial begin
    logic [1:0] cur;
    vec[0]  = '{2'b00, -1000, 300, -1000, 300, -300};
    vec[1]  = '{2'b00, 1000, -50, 1000, -50, -50};
    vec[2]  = '{2'b00, -5, -32768, -5, -32768, 32767};
    vec[3]  = '{2'b00, 0, 0, 0, 0, 0};
    vec[4]  = '{2'b01, 500, -200, -500, -200, 300};
    vec[5]  = '{2'b01, -32768, -32768, 32767, 32767, 0};
    vec[6]  = '{2'b01, -32768, 0, -32768, 0, 32767};
    vec[7]  = '{2'b01, -100, -300, 100, 300, 200};
    vec[8]  = '{2'b01, -300, 100, -300, -100, 200};
    vec[9]  = '{2'b10, -1000, 300, -1000, 300, 0};
    vec[10] = '{2'b11, -1000, 300, -1000, 300, -300};

    // Reset state, then release with a sample that must be blanked.
    rst = 1'b1; mode = 2'b00; drive(1'b0, 0, 0);
    repeat (3) tick();
    chk_reset("reset");
    drive(1'b1, -1000, 300);
    tick();
    rst = 1'b0;
    drive(1'b1, 7, -3);
    chk("rel0.settling", int'(settling), 1);
    chk("rel0.out_tvalid", int'(out_tvalid), 0);
    tick();
    chk("rel1.out_tvalid", int'(out_tvalid), 0);
    drive(1'b0, 0, 0);
    tick();
    chk_out("rel2", 7, -3, 0);
    chk("rel2.settling", int'(settling), 1);
    tick();
    chk("rel3.out_tvalid", int'(out_tvalid), 0);
    chk("rel3.hold_I", int'(out_I_tdata), 7);
    chk("rel3.settling", int'(settling), 1);
    tick();
    chk("rel4.settling", int'(settling), 0);
    cur = 2'b00;

    // Vector table across BPSK, QPSK, HOLD and the reserved code.
    for (int k = 0; k < 11; k++) begin
      mode = vec[k].mode;
      if (map_mode(vec[k].mode) != cur) begin
        cur = map_mode(vec[k].mode);
        tick();
        chk("tbl.chg_settling", int'(settling), 1);
        repeat (4) tick();
      end
      drive(1'b1, vec[k].i, vec[k].q);
      tick();
      drive(1'b0, 0, 0);
      tick();
      chk_out($sformatf("tbl%0d", k), vec[k].ei, vec[k].eq, vec[k].ee);
      chk($sformatf("tbl%0d.mode_active", k), int'(mode_active), int'(cur));
    end

    // Lock: four in-threshold errors lock, one large error drops and restarts.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1000, 50);
      tick();
    end
    drive(1'b0, 0, 0);
    tick();
    chk("lock.error", int'(error_tdata), 50);
    tick();
    chk("lock.pre", int'(locked), 0);
    tick();
    chk("lock.set", int'(locked), 1);
    drive(1'b1, 1000, 150);
    tick();
    drive(1'b0, 0, 0);
    tick();
    chk("lock.big_err", int'(error_tdata), 150);
    chk("lock.still", int'(locked), 1);
    tick();
    chk("lock.drop", int'(locked), 0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1000, 50);
      tick();
    end
    drive(1'b0, 0, 0);
    repeat (4) tick();
    chk("lock.restart3", int'(locked), 0);
    drive(1'b1, 1000, 50);
    tick();
    drive(1'b0, 0, 0);
    repeat (3) tick();
    chk("lock.restart4", int'(locked), 1);

    // Mode switch while locked: settle window, blanked errors, lock cleared.
    mode = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("chg%0d.settling", c), int'(settling), (c <= 4) ? 1 : 0);
      if (c == 1) begin
        chk("chg.mode_active", int'(mode_active), 1);
        chk("chg.locked", int'(locked), 0);
      end
      if (c >= 3) chk_out($sformatf("chg%0d", c), -500, -200, 0);
      if (c <= 4) drive(1'b1, 500, -200);
      else        drive(1'b0, 0, 0);
    end

    // Second change mid-settle restarts the window.
    mode = 2'b00;
    tick();
    tick();
    mode = 2'b01;
    chk("restart.settling2", int'(settling), 1);
    for (int c = 3; c <= 7; c++) begin
      tick();
      if (c == 3) chk("restart.mode_active", int'(mode_active), 1);
      chk($sformatf("restart%0d.settling", c), int'(settling), (c <= 6) ? 1 : 0);
    end

    // HOLD: zero errors with valids high must not build up lock.
    mode = 2'b10;
    tick();
    chk("hold.mode_active", int'(mode_active), 2);
    repeat (4) tick();
    for (int c = 0; c < 8; c++) begin
      if (c >= 2 && c <= 6) chk_out($sformatf("hold%0d", c), -1000, 300, 0);
      if (c < 5) drive(1'b1, -1000, 300);
      else       drive(1'b0, 0, 0);
      tick();
    end
    repeat (3) tick();
    chk("hold.locked", int'(locked), 0);

    // Relock in BPSK, then reset mid-stream.
    mode = 2'b00;
    tick();
    repeat (4) tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1000, -50);
      tick();
    end
    drive(1'b0, 0, 0);
    repeat (3) tick();
    chk("relock.locked", int'(locked), 1);
    drive(1'b1, 1234, -4321);
    tick();
    tick();
    chk_out("stream", 1234, -4321, -4321);
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    tick();
    chk("midrst1.out_tvalid", int'(out_tvalid), 0);
    chk("midrst1.settling", int'(settling), 1);
    tick();
    chk_out("midrst2", 1234, -4321, 0);
    chk("midrst2.settling", int'(settling), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
